// File: rtl/qpi_rd_rsp_pkg.sv
// Shared types and constants for the CCI channel-0 read response return path.
// The rx0 mdata MSB selects which client owns a response.
package qpi_rd_rsp_pkg;

    localparam int RD_MDATA_W = 13;
    localparam int RD_DATA_W  = 512;
    localparam int RD_DEPTH   = 16;
    localparam int TAG_BIT    = RD_MDATA_W - 1;

    typedef struct packed {
        logic [RD_MDATA_W-1:0] mdata;
        logic [RD_DATA_W-1:0]  data;
    } rd_rsp_t;

    localparam int RSP_W = $bits(rd_rsp_t);

    typedef enum logic [0:0] {
        RD_CLIENT_READER = 1'b0,
        RD_CLIENT_WRITER = 1'b1
    } rd_client_t;

endpackage

// File: rtl/cci_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO of read responses.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module cci_rsp_fifo
    import qpi_rd_rsp_pkg::*;
#(
    parameter int DEPTH = RD_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [RSP_W-1:0] din,
    input  logic             pop,
    output logic [RSP_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    rd_rsp_t       mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A beat arriving on a full FIFO is dropped; stored entries stay intact.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= rd_rsp_t'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Head is read combinationally so a response is visible the cycle after it is written.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/cci_read_response_router.sv
// Routes CCI rx0 read responses to per-client FIFOs and issues read credits.
// Optional per-client pop counters are built when CCI_RD_RSP_STATS_EN is defined.
module cci_read_response_router
    import qpi_rd_rsp_pkg::*;
#(
    parameter int DEPTH   = RD_DEPTH,
    parameter int MDATA_W = RD_MDATA_W,
    parameter int DATA_W  = RD_DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx0_rdvalid,
    input  logic [MDATA_W-1:0] rx0_mdata,
    input  logic [DATA_W-1:0]  rx0_data,
    input  logic               issue_reader,
    input  logic               issue_writer,
    output logic               credit_reader,
    output logic               credit_writer,
    output logic               rsp_valid_reader,
    output logic [MDATA_W-1:0] rsp_mdata_reader,
    output logic [DATA_W-1:0]  rsp_data_reader,
    input  logic               rsp_ready_reader,
    output logic               rsp_valid_writer,
    output logic [MDATA_W-1:0] rsp_mdata_writer,
    output logic [DATA_W-1:0]  rsp_data_writer,
    input  logic               rsp_ready_writer,
    output logic               overflow,
    output logic [31:0]        rsp_count_reader,
    output logic [31:0]        rsp_count_writer
);
    localparam int CW = $clog2(DEPTH + 1);

    logic       in_valid_reg;
    rd_rsp_t    in_beat_reg;
    rd_client_t in_client;
    logic       overflow_reg;

    logic [1:0] issue, ready, valid, push, pop, full, empty, credit, err;
    rd_rsp_t    head [2];
    logic [31:0] count [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_reg <= 1'b0;
        end else begin
            in_valid_reg <= rx0_rdvalid;
        end
        in_beat_reg.mdata <= rx0_mdata;
        in_beat_reg.data  <= rx0_data;
    end

    assign in_client = rd_client_t'(in_beat_reg.mdata[TAG_BIT]);
    assign issue     = {issue_writer, issue_reader};
    assign ready     = {rsp_ready_writer, rsp_ready_reader};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_client
            localparam rd_client_t CLIENT = (gi == 0) ? RD_CLIENT_READER : RD_CLIENT_WRITER;
            logic [RSP_W-1:0] dout;
            logic [CW-1:0]    outstanding_reg;

            assign push[gi] = in_valid_reg && (in_client == CLIENT);

            cci_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[gi]),
                .din   (in_beat_reg),
                .pop   (pop[gi]),
                .dout  (dout),
                .full  (full[gi]),
                .empty (empty[gi])
            );

            assign head[gi]   = rd_rsp_t'(dout);
            assign valid[gi]  = !empty[gi];
            assign pop[gi]    = valid[gi] && ready[gi];
            assign credit[gi] = (outstanding_reg < CW'(DEPTH));
            assign err[gi]    = (push[gi] && full[gi]) || (issue[gi] && !credit[gi]);

            // Outstanding reserves a FIFO slot from issue until the response is consumed.
            always_ff @(posedge clk) begin
                if (reset) begin
                    outstanding_reg <= '0;
                end else if (issue[gi] && !pop[gi]) begin
                    if (outstanding_reg != CW'(DEPTH)) outstanding_reg <= outstanding_reg + 1'b1;
                end else if (pop[gi] && !issue[gi]) begin
                    if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - 1'b1;
                end
            end

`ifdef CCI_RD_RSP_STATS_EN
            logic [31:0] count_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (pop[gi]) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
            assign count[gi] = count_reg;
`else
            assign count[gi] = '0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (|err) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow         = overflow_reg;
    assign credit_reader    = credit[0];
    assign credit_writer    = credit[1];
    assign rsp_valid_reader = valid[0];
    assign rsp_mdata_reader = head[0].mdata;
    assign rsp_data_reader  = head[0].data;
    assign rsp_valid_writer = valid[1];
    assign rsp_mdata_writer = head[1].mdata;
    assign rsp_data_writer  = head[1].data;
    assign rsp_count_reader = count[0];
    assign rsp_count_writer = count[1];

endmodule

// File: tb/tb_cci_read_response_router.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor checks every pop.
module tb_cci_read_response_router;
    localparam int MW = 13;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx0_rdvalid = 1'b0;
    logic [MW-1:0] rx0_mdata = '0;
    logic [DW-1:0] rx0_data = '0;
    logic          issue_reader = 1'b0, issue_writer = 1'b0;
    logic          credit_reader, credit_writer;
    logic          rsp_valid_reader, rsp_valid_writer;
    logic [MW-1:0] rsp_mdata_reader, rsp_mdata_writer;
    logic [DW-1:0] rsp_data_reader, rsp_data_writer;
    logic          rsp_ready_reader = 1'b0, rsp_ready_writer = 1'b0;
    logic          overflow;
    logic [31:0]   rsp_count_reader, rsp_count_writer;

    int total = 0;
    int bad = 0;
    logic [MW+DW-1:0] q_rd[$];
    logic [MW+DW-1:0] q_wr[$];
    logic [DW-1:0]    first_data;

    cci_read_response_router dut (
        .clk(clk), .reset(reset),
        .rx0_rdvalid(rx0_rdvalid), .rx0_mdata(rx0_mdata), .rx0_data(rx0_data),
        .issue_reader(issue_reader), .issue_writer(issue_writer),
        .credit_reader(credit_reader), .credit_writer(credit_writer),
        .rsp_valid_reader(rsp_valid_reader), .rsp_mdata_reader(rsp_mdata_reader),
        .rsp_data_reader(rsp_data_reader), .rsp_ready_reader(rsp_ready_reader),
        .rsp_valid_writer(rsp_valid_writer), .rsp_mdata_writer(rsp_mdata_writer),
        .rsp_data_writer(rsp_data_writer), .rsp_ready_writer(rsp_ready_writer),
        .overflow(overflow),
        .rsp_count_reader(rsp_count_reader), .rsp_count_writer(rsp_count_writer)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [31:0] n);
        return {16{n}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic send(input logic [MW-1:0] md, input logic [DW-1:0] d, input bit expect_it);
        rx0_rdvalid = 1'b1;
        rx0_mdata   = md;
        rx0_data    = d;
        if (expect_it) begin
            if (md[MW-1]) q_wr.push_back({md, d});
            else          q_rd.push_back({md, d});
        end
        tick();
        rx0_rdvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_ready_reader = 1'b0;
        rsp_ready_writer = 1'b0;
        issue_reader = 1'b0;
        issue_writer = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid_rd", 64'(rsp_valid_reader), 64'd0);
        check("rst_valid_wr", 64'(rsp_valid_writer), 64'd0);
        check("rst_credit_rd", 64'(credit_reader), 64'd1);
        check("rst_credit_wr", 64'(credit_writer), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
    endtask

    // Monitor: every handshake pops the matching scoreboard queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid_reader && rsp_ready_reader) begin
                total++;
                if (q_rd.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected got mdata=%0h want=none", rsp_mdata_reader);
                end else begin
                    automatic logic [MW+DW-1:0] e = q_rd.pop_front();
                    if ({rsp_mdata_reader, rsp_data_reader} !== e) begin
                        bad++;
                        $display("FAIL rd_rsp got mdata=%0h data=%0h want mdata=%0h data=%0h",
                                 rsp_mdata_reader, rsp_data_reader[31:0], e[MW+DW-1:DW], e[31:0]);
                    end else begin
                        $display("ok   rd_rsp mdata=%0h data=%0h", rsp_mdata_reader, rsp_data_reader[31:0]);
                    end
                end
            end
            if (rsp_valid_writer && rsp_ready_writer) begin
                total++;
                if (q_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got mdata=%0h want=none", rsp_mdata_writer);
                end else begin
                    automatic logic [MW+DW-1:0] e = q_wr.pop_front();
                    if ({rsp_mdata_writer, rsp_data_writer} !== e) begin
                        bad++;
                        $display("FAIL wr_rsp got mdata=%0h data=%0h want mdata=%0h data=%0h",
                                 rsp_mdata_writer, rsp_data_writer[31:0], e[MW+DW-1:DW], e[31:0]);
                    end else begin
                        $display("ok   wr_rsp mdata=%0h data=%0h", rsp_mdata_writer, rsp_data_writer[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // 1: single reader read, two-cycle latency, pass-through.
        issue_reader = 1'b1;
        tick();
        issue_reader = 1'b0;
        send(13'h0005, pat(32'hCAFE_0005), 1'b1);
        check("t1_valid_lat1", 64'(rsp_valid_reader), 64'd0);
        tick();
        check("t1_valid_lat2", 64'(rsp_valid_reader), 64'd1);
        check("t1_mdata", 64'(rsp_mdata_reader), 64'h0005);
        check("t1_data", rsp_data_reader[63:0], {2{32'hCAFE_0005}});
        rsp_ready_reader = 1'b1;
        tick();
        rsp_ready_reader = 1'b0;
        check("t1_empty", 64'(rsp_valid_reader), 64'd0);

        // 2: writer credit exhaustion and recovery.
        send(13'h1ABC, pat(32'h0000_1ABC), 1'b1);
        for (int i = 0; i < 16; i++) begin
            issue_writer = 1'b1;
            tick();
            if (i == 14) check("t2_credit_at15", 64'(credit_writer), 64'd1);
        end
        issue_writer = 1'b0;
        check("t2_credit_at16", 64'(credit_writer), 64'd0);
        rsp_ready_writer = 1'b1;
        tick();
        rsp_ready_writer = 1'b0;
        check("t2_credit_back", 64'(credit_writer), 64'd1);

        // 3: interleaved tags, order per client, two entries each.
        send(13'h0011, pat(32'hA000_0011), 1'b1);
        send(13'h1022, pat(32'hB000_1022), 1'b1);
        send(13'h0033, pat(32'hA000_0033), 1'b1);
        send(13'h1044, pat(32'hB000_1044), 1'b1);
        tick();
        tick();
        check("t3_overflow", 64'(overflow), 64'd0);
        check("t3_head_rd", 64'(rsp_mdata_reader), 64'h0011);
        check("t3_head_wr", 64'(rsp_mdata_writer), 64'h1022);
        rsp_ready_reader = 1'b1;
        rsp_ready_writer = 1'b1;
        tick();
        tick();
        rsp_ready_reader = 1'b0;
        rsp_ready_writer = 1'b0;
        check("t3_drained_rd", 64'(rsp_valid_reader), 64'd0);
        check("t3_drained_wr", 64'(rsp_valid_writer), 64'd0);

        // 4: issue and pop together at full outstanding.
        do_reset();
        send(13'h0077, pat(32'h0000_0077), 1'b1);
        send(13'h0078, pat(32'h0000_0078), 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            issue_reader = 1'b1;
            tick();
        end
        issue_reader = 1'b0;
        check("t4_credit_full", 64'(credit_reader), 64'd0);
        check("t4_no_ovf_yet", 64'(overflow), 64'd0);
        issue_reader = 1'b1;
        rsp_ready_reader = 1'b1;
        tick();
        issue_reader = 1'b0;
        rsp_ready_reader = 1'b0;
        check("t4_credit_stays", 64'(credit_reader), 64'd0);
        check("t4_ovf_nocredit", 64'(overflow), 64'd1);
        rsp_ready_reader = 1'b1;
        tick();
        rsp_ready_reader = 1'b0;
        check("t4_credit_after_pop", 64'(credit_reader), 64'd1);

        // 5: reader FIFO overflow drops the 17th beat.
        do_reset();
        first_data = pat(32'h5000_0000);
        for (int i = 0; i < 16; i++) begin
            send(MW'(i), pat(32'h5000_0000 + 32'(i)), 1'b1);
        end
        tick();
        tick();
        check("t5_ovf_before", 64'(overflow), 64'd0);
        send(13'h0099, pat(32'hDEAD_0099), 1'b0);
        tick();
        tick();
        check("t5_ovf_after", 64'(overflow), 64'd1);
        check("t5_head_mdata", 64'(rsp_mdata_reader), 64'h0000);
        check("t5_head_data", rsp_data_reader[63:0], first_data[63:0]);
        rsp_ready_reader = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        rsp_ready_reader = 1'b0;
        check("t5_drained", 64'(rsp_valid_reader), 64'd0);
        check("t5_ovf_sticky", 64'(overflow), 64'd1);

        // 6: pop statistics.
        do_reset();
        for (int i = 0; i < 5; i++) send(MW'(8'h60 + i), pat(32'h6000_0000 + 32'(i)), 1'b1);
        for (int i = 0; i < 3; i++) send(MW'(13'h1060 + i), pat(32'h7000_0000 + 32'(i)), 1'b1);
        tick();
        tick();
        rsp_ready_reader = 1'b1;
        rsp_ready_writer = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rsp_ready_reader = 1'b0;
        rsp_ready_writer = 1'b0;
`ifdef CCI_RD_RSP_STATS_EN
        check("t6_count_rd", 64'(rsp_count_reader), 64'd5);
        check("t6_count_wr", 64'(rsp_count_writer), 64'd3);
`else
        check("t6_count_rd", 64'(rsp_count_reader), 64'd0);
        check("t6_count_wr", 64'(rsp_count_writer), 64'd0);
`endif
        do_reset();
        check("t6_count_rd_rst", 64'(rsp_count_reader), 64'd0);
        check("t6_count_wr_rst", 64'(rsp_count_writer), 64'd0);

        check("sb_rd_left", 64'(q_rd.size()), 64'd0);
        check("sb_wr_left", 64'(q_wr.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
